// File: rtl/spi_reg_slave.sv
// SPI mode-3 responder exposing a 64 x 8-bit register bank with ADXL345-style framing.
// SCLK/MOSI/SS_n are oversampled in the clk domain; completed writes are reported on a strobe.
`timescale 1ns/1ps

module spi_reg_slave #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       wr_valid,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Input synchronizers plus one edge-detect flop per edge-sensitive line.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    // ss chain resets low so an ss_n held low through reset never looks like a fresh frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b1;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign ss_rise   =  ss_s   & ~ss_prev_q;
    assign ss_fall   = ~ss_s   &  ss_prev_q;

    // Frame state and datapath registers.
    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       rnw_q, rnw_d;
    logic       mb_q, mb_d;
    logic [5:0] addr_q, addr_d;
    logic       miso_q, miso_d;
    logic       wr_valid_q, wr_valid_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic [7:0] regs_q [64];

    logic       reg_we;
    logic [5:0] reg_waddr;
    logic [7:0] reg_wdata;

    // rx_shift only holds the first seven bits; the eighth arrives live on the 8th rise.
    logic [7:0] byte_in;
    logic [5:0] next_addr;
    logic [7:0] rd_cmd;
    logic [7:0] rd_next;

    assign byte_in   = {rx_shift_q, mosi_s};
    assign next_addr = mb_q ? (addr_q + 6'd1) : addr_q;
    assign rd_cmd    = regs_q[byte_in[5:0]];
    assign rd_next   = regs_q[next_addr];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rnw_d      = rnw_q;
        mb_d       = mb_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        reg_we     = 1'b0;
        reg_waddr  = addr_q;
        reg_wdata  = byte_in;

        if (ss_rise) begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_shift_d = byte_in[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rnw_d     = byte_in[7];
                            mb_d      = byte_in[6];
                            addr_d    = byte_in[5:0];
                            bit_cnt_d = 3'd0;
                            state_d   = ST_DATA;
                            if (byte_in[7]) begin
                                tx_shift_d = rd_cmd;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall && rnw_q) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_shift_d = byte_in[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            addr_d    = next_addr;
                            if (rnw_q) begin
                                tx_shift_d = rd_next;
                            end else if (addr_q != 6'd0) begin
                                reg_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = addr_q;
                                wr_data_d  = byte_in;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            tx_shift_q <= 8'd0;
            rnw_q      <= 1'b0;
            mb_q       <= 1'b0;
            addr_q     <= 6'd0;
            miso_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 6'd0;
            wr_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rnw_q      <= rnw_d;
            mb_q       <= mb_d;
            addr_q     <= addr_d;
            miso_q     <= miso_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Entry 0 is never written, so it stays at DEVID.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= (i == 0) ? DEVID : 8'h00;
            end
        end else if (reg_we) begin
            regs_q[reg_waddr] <= reg_wdata;
        end
    end

    assign miso      = miso_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a mode-3 SPI master at 1 MHz, a write-strobe
// scoreboard and hand-computed readback values.
`timescale 1ns/1ps

module tb_spi_reg_slave;

  localparam time CLK_HALF = 10ns;
  localparam time SPI_HALF = 500ns;
  localparam time SS_GAP   = 200ns;

  logic       clk;
  logic       reset_n;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;
  logic       wr_valid;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];
  logic [13:0] exp_q [$];
  logic [13:0] got_q [$];

  spi_reg_slave dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .miso      (miso),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end

  // strobe monitor: one entry per clk cycle that wr_valid is high
  always @(negedge clk) begin
    if (wr_valid) got_q.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic check_strobes(input string tag);
    logic [13:0] e;
    logic [13:0] g;
    check({tag, "_nstrobe"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 14'h3fff;
      check({tag, "_strobe"}, g, e);
    end
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // driver: nbytes full bytes then 'partial' bits of tx_buf[nbytes]; rst_bit >= 0 injects reset
  task automatic spi_xfer(input int nbytes, input int partial, input int rst_bit);
    int b;
    int nb;
    b = 0;
    ss_n = 1'b0;
    #SS_GAP;
    check("busy_in_frame", busy, 1);
    for (int i = 0; i <= nbytes; i++) begin
      nb = (i < nbytes) ? 8 : partial;
      rx_buf[i] = 8'h00;
      for (int j = 0; j < nb; j++) begin
        if (b == rst_bit) begin
          reset_n = 1'b0;
          ss_n    = 1'b1;
          sclk    = 1'b1;
          #100ns;
          check_reset_outputs("midrst");
          reset_n = 1'b1;
          #400ns;
          return;
        end
        sclk = 1'b0;
        mosi = tx_buf[i][7-j];
        #SPI_HALF;
        sclk = 1'b1;
        rx_buf[i][7-j] = miso;
        #SPI_HALF;
        b++;
      end
    end
    #SS_GAP;
    ss_n = 1'b1;
    #400ns;
    check("busy_idle", busy, 0);
    check("miso_idle", miso, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    ss_n    = 1'b1;
    sclk    = 1'b1;
    mosi    = 1'b0;
    #103ns;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    #300ns;

    // DEVID read
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
    spi_xfer(2, 0, -1);
    check("t1_cmd_miso", rx_buf[0], 8'h00);
    check("t1_devid", rx_buf[1], 8'hE5);
    check_strobes("t1");

    // single write then readback
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h3C;
    spi_xfer(2, 0, -1);
    exp_q.push_back({6'd5, 8'h3C});
    check_strobes("t2_wr");
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h00;
    spi_xfer(2, 0, -1);
    check("t2_rd", rx_buf[1], 8'h3C);
    check_strobes("t2_rd");

    // multi-byte write across the 63 -> 0 wrap
    tx_buf[0] = 8'h7E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    spi_xfer(4, 0, -1);
    exp_q.push_back({6'd62, 8'h11});
    exp_q.push_back({6'd63, 8'h22});
    check_strobes("t3_wr");
    tx_buf[0] = 8'hFE; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    spi_xfer(4, 0, -1);
    check("t3_rd62", rx_buf[1], 8'h11);
    check("t3_rd63", rx_buf[2], 8'h22);
    check("t3_rd0", rx_buf[3], 8'hE5);
    check_strobes("t3_rd");

    // partial byte is discarded
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'hAA;
    spi_xfer(2, 0, -1);
    exp_q.push_back({6'd10, 8'hAA});
    check_strobes("t4_wr");
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h55;
    spi_xfer(1, 5, -1);
    check_strobes("t4_partial");
    tx_buf[0] = 8'h8A; tx_buf[1] = 8'h00;
    spi_xfer(2, 0, -1);
    check("t4_rd", rx_buf[1], 8'hAA);
    check_strobes("t4_rd");

    // address 0 is read-only
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h12;
    spi_xfer(2, 0, -1);
    check_strobes("t5_wr");
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
    spi_xfer(2, 0, -1);
    check("t5_rd", rx_buf[1], 8'hE5);

    // reset during byte 2 of a multi-byte write to 20,21,22
    tx_buf[0] = 8'h54; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    spi_xfer(4, 0, 19);
    exp_q.push_back({6'd20, 8'h11});
    check_strobes("t6_wr");
    tx_buf[0] = 8'hD4; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_xfer(3, 0, -1);
    check("t6_rd20", rx_buf[1], 8'h00);
    check("t6_rd21", rx_buf[2], 8'h00);
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h00;
    spi_xfer(2, 0, -1);
    check("t6_rd5", rx_buf[1], 8'h00);
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h77;
    spi_xfer(2, 0, -1);
    exp_q.push_back({6'd5, 8'h77});
    check_strobes("t6_after");
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h00;
    spi_xfer(2, 0, -1);
    check("t6_rd5_new", rx_buf[1], 8'h77);
    check_strobes("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
